// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 CBC sequencer: block width, FSM states,
// mode encoding and the standard SM4 single-block test vector.
package sm4_pkg;

   localparam int SM4_BLK_W = 128;

   localparam logic SM4_ENC = 1'b0;
   localparam logic SM4_DEC = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYLOAD,
      ST_KEYWAIT,
      ST_ACCEPT,
      ST_ISSUE,
      ST_WAIT,
      ST_OUTPUT
   } cbc_state_t;

   localparam logic [SM4_BLK_W-1:0] SM4_TV_KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [SM4_BLK_W-1:0] SM4_TV_PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [SM4_BLK_W-1:0] SM4_TV_CT  = 128'h681edf34d206965e86b3e94f536e4246;

endpackage

// File: rtl/sm4_cbc_datapath.sv
// CBC chaining datapath: chain register, raw-input latch and the XOR muxing
// around the block cipher, sequenced by strobes from the control FSM.
module sm4_cbc_datapath
   import sm4_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mode,
   input  logic                 load_iv,
   input  logic [SM4_BLK_W-1:0] iv,
   input  logic                 accept,
   input  logic [SM4_BLK_W-1:0] din,
   input  logic                 din_last,
   input  logic                 capture,
   input  logic [SM4_BLK_W-1:0] result,
   output logic [SM4_BLK_W-1:0] core_in,
   output logic [SM4_BLK_W-1:0] dout,
   output logic                 dout_last
);

   logic [SM4_BLK_W-1:0] chain;
   logic [SM4_BLK_W-1:0] raw;

   // Decrypt chains on the ciphertext that went in, encrypt on what came out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain <= '0;
      end else if (load_iv) begin
         chain <= iv;
      end else if (capture) begin
         chain <= (mode == SM4_DEC) ? raw : result;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         core_in   <= (mode == SM4_DEC) ? din : (din ^ chain);
         raw       <= din;
         dout_last <= din_last;
      end
      if (capture) begin
         dout <= (mode == SM4_DEC) ? (result ^ chain) : result;
      end
   end

endmodule

// File: rtl/sm4_cbc_ctrl.sv
// CBC-mode sequencer around sm4_top: key expansion, one block in flight,
// rising-edge result capture and a timeout on every core wait.
module sm4_cbc_ctrl
   import sm4_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_in,
   input  logic                 mode_in,
   input  logic [SM4_BLK_W-1:0] key_in,
   input  logic [SM4_BLK_W-1:0] iv_in,
   input  logic                 din_valid_in,
   output logic                 din_ready_out,
   input  logic [SM4_BLK_W-1:0] din_in,
   input  logic                 din_last_in,
   output logic                 dout_valid_out,
   input  logic                 dout_ready_in,
   output logic [SM4_BLK_W-1:0] dout_out,
   output logic                 dout_last_out,
   output logic                 busy_out,
   output logic                 error_out,
   output logic                 core_sm4_enable_out,
   output logic                 core_encdec_enable_out,
   output logic                 core_encdec_sel_out,
   output logic                 core_enable_key_exp_out,
   output logic                 core_user_key_valid_out,
   output logic                 core_valid_out,
   output logic [SM4_BLK_W-1:0] core_user_key_out,
   output logic [SM4_BLK_W-1:0] core_data_out,
   input  logic                 core_ready_in,
   input  logic                 core_key_exp_ready_in,
   input  logic [SM4_BLK_W-1:0] core_result_in
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   cbc_state_t           state, state_next;
   logic                 mode_q;
   logic [SM4_BLK_W-1:0] key_q;
   logic [CNT_W-1:0]     cnt;
   logic                 rdy_q;
   logic                 load_iv, accept, capture, tmo, cnt_hit;
   logic [SM4_BLK_W-1:0] core_in_q, dout_q;
   logic                 last_q;

   assign cnt_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign busy_out = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         mode_q    <= 1'b0;
         key_q     <= '0;
         error_out <= 1'b0;
         cnt       <= '0;
         rdy_q     <= 1'b0;
      end else begin
         state <= state_next;
         rdy_q <= core_ready_in;
         if (load_iv) begin
            mode_q    <= mode_in;
            key_q     <= key_in;
            error_out <= 1'b0;
         end else if (tmo) begin
            error_out <= 1'b1;
         end
         // Counter restarts on every state change so each wait gets a full budget.
         if (state != state_next) begin
            cnt <= '0;
         end else if (state == ST_KEYWAIT || state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next              = state;
      load_iv                 = 1'b0;
      accept                  = 1'b0;
      capture                 = 1'b0;
      tmo                     = 1'b0;
      din_ready_out           = 1'b0;
      dout_valid_out          = 1'b0;
      dout_out                = '0;
      dout_last_out           = 1'b0;
      core_sm4_enable_out     = (state != ST_IDLE);
      core_encdec_sel_out     = (state != ST_IDLE) && mode_q;
      core_encdec_enable_out  = 1'b0;
      core_enable_key_exp_out = 1'b0;
      core_user_key_valid_out = 1'b0;
      core_valid_out          = 1'b0;
      core_user_key_out       = '0;
      core_data_out           = '0;
      case (state)
         ST_IDLE: begin
            if (start_in) begin
               load_iv    = 1'b1;
               state_next = ST_KEYLOAD;
            end
         end
         ST_KEYLOAD: begin
            core_enable_key_exp_out = 1'b1;
            core_user_key_valid_out = 1'b1;
            core_user_key_out       = key_q;
            state_next              = ST_KEYWAIT;
         end
         ST_KEYWAIT: begin
            core_enable_key_exp_out = 1'b1;
            if (core_key_exp_ready_in) begin
               state_next = ST_ACCEPT;
            end else if (cnt_hit) begin
               tmo        = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_ACCEPT: begin
            core_encdec_enable_out = 1'b1;
            din_ready_out          = 1'b1;
            if (din_valid_in) begin
               accept     = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_encdec_enable_out = 1'b1;
            core_valid_out         = 1'b1;
            core_data_out          = core_in_q;
            state_next             = ST_WAIT;
         end
         ST_WAIT: begin
            core_encdec_enable_out = 1'b1;
            // A ready level left over from the previous block is not a new result.
            if (core_ready_in && !rdy_q) begin
               capture    = 1'b1;
               state_next = ST_OUTPUT;
            end else if (cnt_hit) begin
               tmo        = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_OUTPUT: begin
            core_encdec_enable_out = 1'b1;
            dout_valid_out         = 1'b1;
            dout_out               = dout_q;
            dout_last_out          = last_q;
            if (dout_ready_in) begin
               state_next = last_q ? ST_IDLE : ST_ACCEPT;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   sm4_cbc_datapath u_datapath (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode      (mode_q),
      .load_iv   (load_iv),
      .iv        (iv_in),
      .accept    (accept),
      .din       (din_in),
      .din_last  (din_last_in),
      .capture   (capture),
      .result    (core_result_in),
      .core_in   (core_in_q),
      .dout      (dout_q),
      .dout_last (last_q)
   );

endmodule

// File: tb/tb_sm4_cbc_ctrl.sv
// Directed bench for sm4_cbc_ctrl with a behavioural stand-in for sm4_top.
module tb_sm4_cbc_ctrl;

   localparam logic [127:0] TV_KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] TV_PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] TV_CT  = 128'h681edf34d206965e86b3e94f536e4246;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_n = 1'b0, start_in = 1'b0, mode_in = 1'b0;
   logic [127:0] key_in = '0, iv_in = '0, din_in = '0;
   logic         din_valid_in = 1'b0, din_last_in = 1'b0, dout_ready_in = 1'b0;
   logic         din_ready_out, dout_valid_out, dout_last_out, busy_out, error_out;
   logic [127:0] dout_out, core_user_key_out, core_data_out;
   logic         core_sm4_enable_out, core_encdec_enable_out, core_encdec_sel_out;
   logic         core_enable_key_exp_out, core_user_key_valid_out, core_valid_out;

   logic         kx_rdy = 1'b0, res_rdy = 1'b0, m_sel = 1'b0;
   logic [127:0] m_key = '0, m_in = '0, m_res = '0;
   int           kx_cnt = 0, d_cnt = 0;
   logic         hang_res = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [261:0] core_outs;
   logic [394:0] all_outs;
   assign core_outs = {core_sm4_enable_out, core_encdec_enable_out, core_encdec_sel_out,
                       core_enable_key_exp_out, core_user_key_valid_out, core_valid_out,
                       core_user_key_out, core_data_out};
   assign all_outs  = {core_outs, din_ready_out, dout_valid_out, dout_out, dout_last_out,
                       busy_out, error_out};

   sm4_cbc_ctrl dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .start_in                (start_in),
      .mode_in                 (mode_in),
      .key_in                  (key_in),
      .iv_in                   (iv_in),
      .din_valid_in            (din_valid_in),
      .din_ready_out           (din_ready_out),
      .din_in                  (din_in),
      .din_last_in             (din_last_in),
      .dout_valid_out          (dout_valid_out),
      .dout_ready_in           (dout_ready_in),
      .dout_out                (dout_out),
      .dout_last_out           (dout_last_out),
      .busy_out                (busy_out),
      .error_out               (error_out),
      .core_sm4_enable_out     (core_sm4_enable_out),
      .core_encdec_enable_out  (core_encdec_enable_out),
      .core_encdec_sel_out     (core_encdec_sel_out),
      .core_enable_key_exp_out (core_enable_key_exp_out),
      .core_user_key_valid_out (core_user_key_valid_out),
      .core_valid_out          (core_valid_out),
      .core_user_key_out       (core_user_key_out),
      .core_data_out           (core_data_out),
      .core_ready_in           (res_rdy),
      .core_key_exp_ready_in   (kx_rdy),
      .core_result_in          (m_res)
   );

   // Core stand-in: the real SM4 test vector, and a rotate/XOR bijection elsewhere.
   function automatic logic [127:0] core_fn(input logic [127:0] x, input logic [127:0] k,
                                            input logic sel);
      logic [127:0] t;
      if (!sel) begin
         if (k == TV_KEY && x == TV_PT) return TV_CT;
         return {x[114:0], x[127:115]} ^ k;
      end
      if (k == TV_KEY && x == TV_CT) return TV_PT;
      t = x ^ k;
      return {t[12:0], t[127:13]};
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         kx_rdy  <= 1'b0;
         res_rdy <= 1'b0;
         kx_cnt  <= 0;
         d_cnt   <= 0;
      end else begin
         if (core_enable_key_exp_out && core_user_key_valid_out) begin
            m_key  <= core_user_key_out;
            m_sel  <= core_encdec_sel_out;
            kx_rdy <= 1'b0;
            kx_cnt <= 3;
         end else if (kx_cnt > 0) begin
            kx_cnt <= kx_cnt - 1;
            if (kx_cnt == 1) kx_rdy <= 1'b1;
         end
         if (core_valid_out && core_encdec_enable_out) begin
            m_in    <= core_data_out;
            res_rdy <= 1'b0;
            d_cnt   <= 4;
         end else if (d_cnt > 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1 && !hang_res) begin
               res_rdy <= 1'b1;
               m_res   <= core_fn(m_in, m_key, m_sel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_session(input logic m, input logic [127:0] k, input logic [127:0] iv);
      mode_in  = m;
      key_in   = k;
      iv_in    = iv;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] d, input logic last,
                             input logic [127:0] exp_core, input string tag);
      din_in       = d;
      din_last_in  = last;
      din_valid_in = 1'b1;
      for (int i = 0; i < 100 && !din_ready_out; i++) tick();
      chk({tag, " din_ready"}, din_ready_out, 1);
      tick();
      din_valid_in = 1'b0;
      chk({tag, " core_valid"}, core_valid_out, 1);
      chk({tag, " core_data"}, core_data_out, exp_core);
      tick();
      chk({tag, " core_valid_drop"}, core_valid_out, 0);
   endtask

   task automatic recv_block(input logic [127:0] exp, input logic last, input int stalls,
                             input string tag);
      dout_ready_in = 1'b0;
      for (int i = 0; i < 100 && !dout_valid_out; i++) tick();
      chk({tag, " dout_valid"}, dout_valid_out, 1);
      for (int s = 0; s < stalls; s++) begin
         chk({tag, " stall"}, {dout_valid_out, dout_last_out, dout_out}, {1'b1, last, exp});
         tick();
      end
      dout_ready_in = 1'b1;
      chk({tag, " dout"}, dout_out, exp);
      chk({tag, " dout_last"}, dout_last_out, last);
      tick();
      dout_ready_in = 1'b0;
      if (last) chk({tag, " idle"}, {busy_out, core_outs}, 0);
      else      chk({tag, " next_ready"}, din_ready_out, 1);
   endtask

   logic [127:0] p4 [4];
   logic [127:0] cin4 [4];
   logic [127:0] ct4 [4];
   logic [127:0] iv4, prev;
   int           wc;

   initial begin
      p4[0] = 128'h00112233445566778899aabbccddeeff;
      p4[1] = 128'hdeadbeef0badf00dcafebabe12345678;
      p4[2] = 128'h0;
      p4[3] = 128'hffffffffffffffffffffffffffffffff;
      iv4   = 128'h000102030405060708090a0b0c0d0e0f;
      prev  = iv4;
      for (int i = 0; i < 4; i++) begin
         cin4[i] = p4[i] ^ prev;
         ct4[i]  = core_fn(cin4[i], TV_KEY, 1'b0);
         prev    = ct4[i];
      end

      tick();
      tick();
      chk("reset outputs", all_outs, 0);
      reset_n = 1'b1;
      tick();

      // Single block, IV 0, with KEYLOAD/KEYWAIT timing.
      start_session(1'b0, TV_KEY, '0);
      chk("t1 keyload ctl", {core_sm4_enable_out, core_enable_key_exp_out,
                             core_user_key_valid_out, busy_out, core_encdec_enable_out}, 5'b11110);
      chk("t1 keyload key", core_user_key_out, TV_KEY);
      tick();
      chk("t1 keywait ctl", {core_enable_key_exp_out, core_user_key_valid_out}, 2'b10);
      send_block(TV_PT, 1'b1, TV_PT, "t1");
      recv_block(TV_CT, 1'b1, 0, "t1");

      // IV folded into the first block.
      start_session(1'b0, TV_KEY, TV_PT);
      send_block('0, 1'b1, TV_PT, "t2");
      recv_block(TV_CT, 1'b1, 2, "t2");

      // Decrypt of the test vector with IV = plaintext gives zero.
      start_session(1'b1, TV_KEY, TV_PT);
      chk("t3 sel", core_encdec_sel_out, 1);
      send_block(TV_CT, 1'b1, TV_CT, "t3");
      recv_block('0, 1'b1, 1, "t3");

      // Four-block round trip with stalls and a stray start mid-session.
      start_session(1'b0, TV_KEY, iv4);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            mode_in  = 1'b1;
            key_in   = ~TV_KEY;
            iv_in    = '1;
            start_in = 1'b1;
            tick();
            start_in = 1'b0;
         end
         send_block(p4[i], i == 3, cin4[i], $sformatf("enc%0d", i));
         recv_block(ct4[i], i == 3, int'($urandom_range(0, 3)), $sformatf("enc%0d", i));
      end
      start_session(1'b1, TV_KEY, iv4);
      for (int i = 0; i < 4; i++) begin
         send_block(ct4[i], i == 3, ct4[i], $sformatf("dec%0d", i));
         recv_block(p4[i], i == 3, int'($urandom_range(0, 3)), $sformatf("dec%0d", i));
      end

      // Core never answers: timeout, sticky error, cleared by next start.
      hang_res = 1'b1;
      start_session(1'b0, TV_KEY, '0);
      send_block(TV_PT, 1'b1, TV_PT, "t5");
      wc = 0;
      while (!error_out && wc < 1200) begin
         tick();
         wc++;
      end
      chk("t5 error", error_out, 1);
      chk("t5 wait window", (wc >= 1000 && wc <= 1030), 1);
      chk("t5 idle", {busy_out, core_outs}, 0);
      tick();
      chk("t5 sticky", error_out, 1);
      hang_res = 1'b0;
      start_session(1'b0, TV_KEY, '0);
      chk("t6 error cleared", error_out, 0);

      // Reset while waiting on the core.
      send_block(TV_PT, 1'b1, TV_PT, "t6");
      reset_n = 1'b0;
      tick();
      chk("t6 reset outputs", all_outs, 0);
      reset_n = 1'b1;
      tick();
      start_session(1'b0, TV_KEY, '0);
      send_block(TV_PT, 1'b1, TV_PT, "t7");
      recv_block(TV_CT, 1'b1, 0, "t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sm4_cbc_ctrl.md
# sm4_cbc_ctrl

CBC-mode sequencer that sits directly upstream and downstream of `sm4_top`. It takes 128-bit blocks from a host valid/ready stream and applies cipher-block chaining with an IV. It drives `sm4_top`'s key-expansion and encrypt/decrypt handshakes, and returns chained results on a valid/ready output stream. Each session covers one key and one IV, terminated by a `last` flag.

## Interface
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for the core's key-expansion ready or result ready before flagging an error.
- `clk`  in  1  clock; one clock domain.
- `reset_n`  in  1  synchronous reset, active-low.
- `start_in`  in  1  session start pulse; sampled only in IDLE.
- `mode_in`  in  1  0 = encrypt, 1 = decrypt; latched on start.
- `key_in`  in  128  user key; latched on start.
- `iv_in`  in  128  initialisation vector; latched on start.
- `din_valid_in` / `din_ready_out`  in/out  1  input block handshake.
- `din_in`  in  128  input block.
- `din_last_in`  in  1  marks the final block of the session.
- `dout_valid_out` / `dout_ready_in`  out/in  1  output block handshake.
- `dout_out`  out  128  output block.
- `dout_last_out`  out  1  marks the final output block.
- `busy_out`  out  1  high whenever the FSM is not in IDLE.
- `error_out`  out  1  sticky timeout flag; cleared by the next accepted start.
- `core_sm4_enable_out`, `core_encdec_enable_out`, `core_encdec_sel_out`, `core_enable_key_exp_out`, `core_user_key_valid_out`, `core_valid_out`  out  1 each  connect to the same-named `sm4_top` inputs.
- `core_user_key_out`, `core_data_out`  out  128  connect to `sm4_top` `user_key_in` and `data_in`.
- `core_ready_in`, `core_key_exp_ready_in`  in  1  from `sm4_top` `ready_out` and `key_exp_ready_out`.
- `core_result_in`  in  128  from `sm4_top` `result_out`.

## Operation
- FSM states: IDLE → KEYLOAD → KEYWAIT → ACCEPT → ISSUE → WAIT → OUTPUT → (ACCEPT, or IDLE if last).
- **IDLE**
  - All outputs are 0.
  - `start_in` latches mode, key and IV; sets the chain register to the IV; clears `error_out`.
- **KEYLOAD** (1 cycle)
  - Asserts `core_sm4_enable_out`, `core_enable_key_exp_out` and `core_user_key_valid_out`.
  - Drives `core_user_key_out` with the latched key.
  - Drives `core_encdec_sel_out` with the latched mode. It is held from KEYLOAD until the return to IDLE, because the decrypt key schedule depends on it.
- **KEYWAIT**
  - Keeps the sm4 and key-expansion enables high.
  - Exits to ACCEPT when `core_key_exp_ready_in` is high.
  - `core_encdec_enable_out` goes high on entry to ACCEPT and stays high until IDLE.
- **ACCEPT**
  - `din_ready_out` = 1.
  - On handshake, registers the core input:
    - encrypt: `din_in ^ chain`;
    - decrypt: `din_in`.
  - Also latches the raw `din_in` and `din_last_in`.
- **ISSUE** (1 cycle): `core_valid_out` = 1 and `core_data_out` = the registered value.
- **WAIT**
  - Keeps the previous-cycle value of `core_ready_in` in a register, `rdy_q`.
  - Result is captured on the first cycle where `core_ready_in` = 1 and `rdy_q` = 0, i.e. a rising edge. A level held over from the previous block is ignored.
  - Output block:
    - encrypt: `core_result_in`;
    - decrypt: `core_result_in ^ chain`.
  - Chain update:
    - encrypt: chain ← `core_result_in`;
    - decrypt: chain ← the latched raw `din_in`.
- **OUTPUT**
  - `dout_valid_out` stays high, and `dout_out` / `dout_last_out` stay stable, until `dout_ready_in`.
  - After the handshake: go to IDLE if last (drop all core enables), else go to ACCEPT.
- **Timeout**
  - A counter runs in KEYWAIT and WAIT and resets on state entry.
  - On reaching `TIMEOUT_CYCLES`: set `error_out`, go to IDLE, deassert all core outputs, discard the block in flight.
- **Boundary cases**
  - `start_in` outside IDLE is ignored.
  - `din_valid_in` outside ACCEPT is not accepted.
  - A single-block session (last on the first block) is legal.
  - Reset mid-session returns to IDLE within one cycle with all outputs 0 and the chain cleared.

## Timing
- Reset values: every output is 0; the FSM is in IDLE.
- Start sampled at cycle t → KEYLOAD at t+1 → KEYWAIT from t+2.
- Input handshake at cycle t → `core_valid_out` high at t+1 only.
- Ready edge sampled at cycle r → `dout_valid_out` high at r+1.
- Output handshake at cycle o → `din_ready_out` high at o+1 (non-last).
- Throughput: one block in flight; no overlap.

## Structure
- Shared package `sm4_pkg`:
  - `SM4_BLK_W` = 128;
  - FSM state enum;
  - mode encoding (`SM4_ENC` = 0, `SM4_DEC` = 1);
  - standard test-vector constants.
- Submodule `sm4_cbc_datapath` holds the chain register, raw-input latch, and the pre/post XOR muxing. It is controlled by FSM strobes.

## Test plan
- Encrypt, key `0123456789abcdeffedcba9876543210`, IV 0, single block `0123456789abcdeffedcba9876543210` → `dout_out` = `681edf34d206965e86b3e94f536e4246`, `dout_last_out` = 1, then return to IDLE.
- Encrypt, same key, IV `0123456789abcdeffedcba9876543210`, block 0 → core sees `0123…3210`; `dout_out` = `681edf34d206965e86b3e94f536e4246`.
- Decrypt, same key, IV `0123…3210`, block `681edf34…4246` → `dout_out` = 0.
- Four-block encrypt then decrypt of the resulting ciphertext (same key/IV), with random `dout_ready_in` stalls → plaintext recovered bit-exact; outputs stable during stalls.
- Core model never raises ready → `error_out` = 1 after `TIMEOUT_CYCLES`, FSM in IDLE, all core outputs 0; the next start clears `error_out`.
- `reset_n` low during WAIT → all outputs 0 the next cycle; a `start_in` pulse during a session has no effect.
